// File: rtl/coinc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : coinc_pkg
//  Description : Shared state type and default widths for the coincidence counter.
//  Revision    : 1.0
// ============================================================================
package coinc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        HOLD = 2'd2
    } coinc_state_t;

    localparam int C_NCHAN_DEFAULT = 4;
    localparam int C_WBITS_DEFAULT = 4;
    localparam int C_PBITS_DEFAULT = 24;
    localparam int C_CBITS_DEFAULT = 16;

endpackage
`default_nettype wire

// File: rtl/chan_window.sv
`default_nettype none
// ============================================================================
//  Module      : chan_window
//  Description : Per-channel rising-edge detector and coincidence window timer.
//  Revision    : 1.0
// ============================================================================
module chan_window #(
    parameter int WBITS = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             din,
    input  logic             arm_en,
    input  logic             clear,
    input  logic             consume,
    input  logic [WBITS-1:0] window,
    output logic             live
);

    logic             r_prev;
    logic [WBITS-1:0] r_timer;
    logic             w_rise;
    logic             w_armed;

    assign w_rise  = din & ~r_prev;
    assign w_armed = (r_timer != '0);
    assign live    = w_armed | w_rise;

    // The rise cycle itself is covered by w_rise; the timer covers the
    // following window cycles, so the channel is live for window+1 cycles.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_prev  <= 1'b0;
            r_timer <= '0;
        end else begin
            r_prev <= din;
            if (clear || consume) begin
                r_timer <= '0;
            end else if (arm_en && w_rise) begin
                r_timer <= window;
            end else if (w_armed) begin
                r_timer <= r_timer - WBITS'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/coincidence_counter.sv
`default_nettype none
// ============================================================================
//  Module      : coincidence_counter
//  Description : Windowed multi-channel coincidence detector with a timed,
//                saturating coincidence count and valid/ready result readout.
//  Revision    : 1.0
// ============================================================================
module coincidence_counter
    import coinc_pkg::*;
#(
    parameter int NCHAN = C_NCHAN_DEFAULT,
    parameter int WBITS = C_WBITS_DEFAULT,
    parameter int PBITS = C_PBITS_DEFAULT,
    parameter int CBITS = C_CBITS_DEFAULT
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [NCHAN-1:0] DlayChann,
    input  logic [NCHAN-1:0] Mask,
    input  logic [WBITS-1:0] Window,
    input  logic [PBITS-1:0] Period,
    input  logic             Start,
    input  logic             Abort,
    output logic             CoincPulse,
    output logic [CBITS-1:0] CountOut,
    output logic             CountValid,
    input  logic             CountReady,
    output logic             Busy,
    output logic             Overflow
);

    localparam logic [CBITS-1:0] C_COUNT_MAX = '1;

    coinc_state_t     r_state;
    coinc_state_t     w_state_next;

    logic [NCHAN-1:0] r_mask;
    logic [WBITS-1:0] r_window;
    logic [PBITS-1:0] r_period_cnt;
    logic [CBITS-1:0] r_count;
    logic [CBITS-1:0] r_count_out;
    logic             r_overflow;
    logic             r_pulse;

    logic             w_in_acq;
    logic             w_start_take;
    logic             w_abort;
    logic             w_last;
    logic             w_clear;
    logic             w_hit;
    logic [NCHAN-1:0] w_live;
    logic [NCHAN-1:0] w_consume;
    logic [CBITS-1:0] w_count_inc;
    logic [CBITS-1:0] w_count_next;

    assign w_in_acq     = (r_state == ACQ);
    assign w_start_take = (r_state == IDLE) && Start;
    assign w_abort      = w_in_acq && Abort;
    assign w_last       = w_in_acq && !Abort && (r_period_cnt == PBITS'(1));
    assign w_clear      = w_start_take | w_abort;

    assign w_hit        = w_in_acq && (r_mask != '0) && ((r_mask & ~w_live) == '0);
    assign w_consume    = {NCHAN{w_hit}} & r_mask;

    assign w_count_inc  = (r_count == C_COUNT_MAX) ? r_count : r_count + CBITS'(1);
    assign w_count_next = w_hit ? w_count_inc : r_count;

    generate
        for (genvar i = 0; i < NCHAN; i++) begin : g_chan
            chan_window #(
                .WBITS (WBITS)
            ) u_chan_window (
                .Clk     (Clk),
                .Rst_n   (Rst_n),
                .din     (DlayChann[i]),
                .arm_en  (w_in_acq),
                .clear   (w_clear),
                .consume (w_consume[i]),
                .window  (r_window),
                .live    (w_live[i])
            );
        end
    endgenerate

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (Start) w_state_next = ACQ;
            ACQ: begin
                if (Abort) begin
                    w_state_next = IDLE;
                end else if (r_period_cnt == PBITS'(1)) begin
                    w_state_next = HOLD;
                end
            end
            HOLD:    if (CountReady) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_mask       <= '0;
            r_window     <= '0;
            r_period_cnt <= '0;
            r_count      <= '0;
            r_count_out  <= '0;
            r_overflow   <= 1'b0;
            r_pulse      <= 1'b0;
        end else begin
            r_pulse <= w_hit && !Abort;
            if (w_start_take) begin
                r_mask       <= Mask;
                r_window     <= Window;
                r_period_cnt <= (Period == '0) ? PBITS'(1) : Period;
                r_count      <= '0;
                r_overflow   <= 1'b0;
            end else if (w_in_acq) begin
                r_period_cnt <= r_period_cnt - PBITS'(1);
                r_count      <= w_count_next;
                if (w_hit && (w_count_inc == C_COUNT_MAX)) begin
                    r_overflow <= 1'b1;
                end
            end
            // Includes a coincidence detected in the final acquisition cycle.
            if (w_last) begin
                r_count_out <= w_count_next;
            end
        end
    end

    assign CoincPulse = r_pulse;
    assign CountOut   = r_count_out;
    assign CountValid = (r_state == HOLD);
    assign Busy       = (r_state == ACQ) || (r_state == HOLD);
    assign Overflow   = r_overflow;

endmodule
`default_nettype wire
